booth_product_accumulator: RTL and testbench
============================================

# booth_product_accumulator

Sequential multiply-accumulate back end that sits directly downstream of the combinational 8x8 signed `booth_multiplier`. It consumes that block's 16-bit signed product `z` through a valid/ready handshake and sums a fixed number of products into a wide signed accumulator. It then presents the dot-product result on an output handshake. Overflow is detected, and it is either wrapped or saturated depending on a compile-time switch.

## Interface
- `N_TERMS`, default 8: number of products summed per result; legal range 1..255.
- `ACC_W`, default 24: accumulator width in bits; legal range 16..32.

- `clk` in 1: single clock; all state updates on its rising edge.
- `rst_n` in 1: reset, asynchronous and active-low.
- `start` in 1: begin a new accumulation; sampled only in IDLE.
- `product` in 16: signed product, connected to `booth_multiplier.z`.
- `in_valid` in 1: `product` is valid this cycle.
- `in_ready` out 1: block accepts `product`; combinational, equals (state == ACCUM).
- `acc_out` out ACC_W: signed result, registered.
- `out_valid` out 1: `acc_out` is valid, registered.
- `out_ready` in 1: downstream accepts `acc_out`.
- `overflow` out 1: sticky flag; at least one add in this run overflowed ACC_W.
- `busy` out 1: state != IDLE.

## Operation
- The state machine has three states: IDLE, ACCUM and HOLD.
- **IDLE, on `start`=1:**
  - Clears the accumulator, `overflow` and the term counter.
  - Moves to ACCUM.
- **ACCUM:**
  - A handshake occurs when `in_valid` && `in_ready`.
  - On each handshake, the accumulator becomes acc + sign_extend(product, ACC_W), and the counter increments.
  - On the handshake where counter == N_TERMS-1, the state moves to HOLD.
- **HOLD:**
  - `out_valid`=1 and `acc_out` is stable.
  - When `out_valid` && `out_ready`, the state moves to IDLE.
- **Counter:** 8 bits, compared against N_TERMS-1. It is never allowed to wrap.
- **Overflow detection:** an add overflows when both operands have the same sign and the sum's sign differs from them. When that happens, `overflow` is set and stays set until the next `start`.
- **Overflow result:** wrap or saturate, selected by `BOOTH_ACC_SATURATE_EN` (see Configuration).
- **Values outside the accepting states:**
  - `acc_out` holds its last value in IDLE and ACCUM. It is meaningful only while `out_valid`=1.
  - `product` is ignored whenever `in_ready`=0.
- **`start` outside IDLE:** ignored, with no effect on state or data.
- **N_TERMS=1:** the first handshake goes directly to HOLD.

## Timing
- **Reset values:**
  - state = IDLE
  - `acc_out` = 0
  - `out_valid` = 0
  - `overflow` = 0
  - `busy` = 0
  - `in_ready` = 0
- **Start latency:** if `start` is asserted in cycle t while in IDLE, then `in_ready`=1 and `busy`=1 from cycle t+1.
- **Throughput:** one product per cycle while `in_valid` is held high.
- **Result latency:** if the final handshake occurs in cycle t, then `out_valid`=1 in cycle t+1, with the result including that final product. `in_ready`=0 from cycle t+1.
- **Output handshake:**
  - `out_valid` stays high, with `acc_out` and `overflow` stable, for as long as `out_ready`=0.
  - If the output handshake occurs in cycle t, then `out_valid`=0 and state = IDLE in cycle t+1.
  - A new `start` is therefore first accepted in cycle t+1.
- **Mid-operation reset:** `rst_n` low at any time immediately forces all reset values without waiting for a clock edge. Any partial sum is discarded.

## Configuration
- Macro: `BOOTH_ACC_SATURATE_EN`.
- **Defined:** an overflowing add clamps the accumulator.
  - Positive overflow gives 2^(ACC_W-1)-1.
  - Negative overflow gives -2^(ACC_W-1).
  - Subsequent adds continue from the clamped value.
- **Undefined:** the accumulator wraps modulo 2^ACC_W (two's complement).
- `overflow` is set identically in both builds.

## Test plan
- **Basic sum** (N_TERMS=4, ACC_W=24): start, then products 63, 4, 33, 91 on consecutive cycles → `out_valid`=1 one cycle after the 4th, `acc_out`=191, `overflow`=0.
- **Signed mix** (N_TERMS=3): products -16256, 16384, -1 → `acc_out`=127. Also check that `in_valid` gaps of 2 cycles between terms do not change the result.
- **Overflow** (N_TERMS=2, ACC_W=16): products 32767, 1 → with `BOOTH_ACC_SATURATE_EN`, `acc_out`=32767 and `overflow`=1; without it, `acc_out`=-32768 and `overflow`=1.
- **Output backpressure:** hold `out_ready`=0 for 5 cycles after `out_valid` → `acc_out` and `out_valid` stable, `in_ready`=0. Raise `out_ready` → IDLE the next cycle.
- **Start while busy:** pulse `start` mid-ACCUM after 2 of 4 terms → ignored, counter and sum unaffected, final result correct.
- **Reset mid-run:** drop `rst_n` after 2 of 4 terms → all outputs at reset values immediately. Then a fresh start with products 1, 1, 1, 1 gives `acc_out`=4.

Source files
------------

// File: rtl/booth_product_accumulator_if.sv
// booth_product_accumulator_if: product input and result output handshakes of the accumulator
interface booth_product_accumulator_if #(parameter int ACC_W = 24);
  logic start, in_valid, in_ready, out_valid, out_ready, overflow, busy;
  logic [15:0] product;
  logic [ACC_W-1:0] acc_out;
  modport master(output start, product, in_valid, out_ready, input in_ready, acc_out, out_valid, overflow, busy);
  modport slave(input start, product, in_valid, out_ready, output in_ready, acc_out, out_valid, overflow, busy);
endinterface

// File: rtl/booth_product_accumulator.sv
// booth_product_accumulator: sums N_TERMS signed 16-bit products into an ACC_W accumulator.
// Define BOOTH_ACC_SATURATE_EN to clamp on overflow instead of wrapping.
module booth_product_accumulator #(
  parameter int N_TERMS = 8,
  parameter int ACC_W = 24
) (
  input logic clk,
  input logic rst_n,
  booth_product_accumulator_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;
  state_t state, state_nx;
  logic [7:0] cnt;
  logic [ACC_W-1:0] acc, ext, sum, acc_nx, acc_out;
  logic ovf, ovf_add, hs, last;
  assign ext = ACC_W'($signed(bus.product));
  assign sum = acc + ext;
  assign ovf_add = (acc[ACC_W-1] == ext[ACC_W-1]) && (sum[ACC_W-1] != acc[ACC_W-1]);
`ifdef BOOTH_ACC_SATURATE_EN
  assign acc_nx = !ovf_add ? sum : acc[ACC_W-1] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
`else
  assign acc_nx = sum;
`endif
  assign bus.in_ready = state == ACCUM;
  assign bus.busy = state != IDLE;
  assign bus.acc_out = acc_out;
  assign bus.overflow = ovf;
  assign hs = bus.in_valid && bus.in_ready;
  assign last = cnt == 8'(N_TERMS - 1);
  always_comb begin
    state_nx = state;
    state_nx = (state == IDLE && bus.start) ? ACCUM :
               (hs && last) ? HOLD :
               (state == HOLD && bus.out_ready) ? IDLE : state;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      acc <= '0;
      acc_out <= '0;
      bus.out_valid <= 1'b0;
      ovf <= 1'b0;
      cnt <= '0;
    end else begin
      state <= state_nx;
      bus.out_valid <= state_nx == HOLD;
      if (state == IDLE && bus.start) begin
        acc <= '0;
        ovf <= 1'b0;
        cnt <= '0;
      end else if (hs) begin
        acc <= acc_nx;
        ovf <= ovf | ovf_add;
        cnt <= cnt + 8'd1;
        if (last) acc_out <= acc_nx;
      end
    end
  end
endmodule

// File: tb/tb_booth_product_accumulator.sv
// tb_booth_product_accumulator: scoreboard bench for a 4-term/24-bit and a 2-term/16-bit accumulator
module tb_booth_product_accumulator;
  logic clk = 0;
  logic rst_n = 0;
  int total = 0;
  int bad = 0;
  logic [23:0] model;
  logic [23:0] exp_q[$];
  logic [15:0] exp_qb[$];
  logic ovf_qb[$];
  always #5 clk = ~clk;
  booth_product_accumulator_if #(.ACC_W(24)) a ();
  booth_product_accumulator_if #(.ACC_W(16)) b ();
  booth_product_accumulator #(.N_TERMS(4), .ACC_W(24)) dut_a (.clk(clk), .rst_n(rst_n), .bus(a));
  booth_product_accumulator #(.N_TERMS(2), .ACC_W(16)) dut_b (.clk(clk), .rst_n(rst_n), .bus(b));

  task automatic start_a(input string nm);
    @(negedge clk); a.start = 1;
    @(negedge clk); a.start = 0;
    model = '0;
    total++;
    if (a.in_ready !== 1'b1 || a.busy !== 1'b1) begin
      bad++; $display("FAIL %s start: in_ready=%b busy=%b want 1 1", nm, a.in_ready, a.busy);
    end
  endtask

  task automatic send_a(input logic [15:0] p, input int gap, input string nm);
    int n = 0;
    a.in_valid = 1; a.product = p;
    while (!a.in_ready && n < 20) begin @(negedge clk); n++; end
    if (n == 20) begin
      total++; bad++; $display("FAIL %s in_ready timeout got=%b want 1", nm, a.in_ready);
    end
    model = model + {{8{p[15]}}, p};
    @(negedge clk);
    a.in_valid = 0; a.product = 16'($urandom);
    repeat (gap) @(negedge clk);
  endtask

  task automatic collect_a(input string nm);
    logic [23:0] e;
    int n = 0;
    while (!a.out_valid && n < 50) begin @(negedge clk); n++; end
    total++;
    if (a.out_valid !== 1'b1) begin bad++; $display("FAIL %s out_valid timeout got=%b want 1", nm, a.out_valid); end
    e = exp_q.pop_front();
    total++;
    if (a.acc_out !== e) begin bad++; $display("FAIL %s acc_out got=%0d want=%0d", nm, $signed(a.acc_out), $signed(e)); end
    total++;
    if (a.overflow !== 1'b0) begin bad++; $display("FAIL %s overflow got=%b want 0", nm, a.overflow); end
    a.out_ready = 1;
    @(negedge clk); a.out_ready = 0;
    total++;
    if (a.out_valid !== 1'b0 || a.busy !== 1'b0) begin
      bad++; $display("FAIL %s release: out_valid=%b busy=%b want 0 0", nm, a.out_valid, a.busy);
    end
  endtask

  task automatic test_reset();
    #3;
    total++;
    if ({a.acc_out, a.out_valid, a.overflow, a.busy, a.in_ready} !== 28'd0) begin
      bad++; $display("FAIL reset_a acc=%0h ov=%b of=%b busy=%b rdy=%b want all 0", a.acc_out, a.out_valid, a.overflow, a.busy, a.in_ready);
    end
    total++;
    if ({b.acc_out, b.out_valid, b.overflow, b.busy, b.in_ready} !== 20'd0) begin
      bad++; $display("FAIL reset_b acc=%0h ov=%b of=%b busy=%b rdy=%b want all 0", b.acc_out, b.out_valid, b.overflow, b.busy, b.in_ready);
    end
    @(negedge clk); rst_n = 1;
  endtask

  task automatic test_basic();
    logic [15:0] v[4] = '{16'd63, 16'd4, 16'd33, 16'd91};
    start_a("basic");
    foreach (v[i]) send_a(v[i], 0, "basic");
    exp_q.push_back(model);
    total++;
    if (a.out_valid !== 1'b1 || a.in_ready !== 1'b0) begin
      bad++; $display("FAIL basic latency: out_valid=%b in_ready=%b want 1 0", a.out_valid, a.in_ready);
    end
    total++;
    if (model !== 24'd191) begin bad++; $display("FAIL basic model sum got=%0d want=191", model); end
    collect_a("basic");
  endtask

  task automatic test_signed_mix();
    logic [15:0] v[4] = '{-16'sd16256, 16'sd16384, -16'sd1, 16'sd0};
    for (int g = 0; g <= 2; g += 2) begin
      start_a("mix");
      foreach (v[i]) send_a(v[i], g, "mix");
      exp_q.push_back(model);
      collect_a($sformatf("mix_gap%0d", g));
    end
  endtask

  task automatic test_backpressure();
    logic [15:0] v[4] = '{16'd1000, -16'sd3, 16'd7, 16'd12345};
    logic [23:0] e;
    start_a("bp");
    foreach (v[i]) send_a(v[i], 0, "bp");
    e = model;
    exp_q.push_back(model);
    repeat (5) begin
      total++;
      if (a.out_valid !== 1'b1 || a.in_ready !== 1'b0 || a.acc_out !== e) begin
        bad++; $display("FAIL bp hold: ov=%b rdy=%b acc=%0d want 1 0 %0d", a.out_valid, a.in_ready, $signed(a.acc_out), $signed(e));
      end
      @(negedge clk);
    end
    collect_a("bp");
  endtask

  task automatic test_start_busy();
    logic [15:0] v[4] = '{16'd500, 16'd600, -16'sd50, 16'd9};
    start_a("sbusy");
    send_a(v[0], 0, "sbusy");
    send_a(v[1], 0, "sbusy");
    a.start = 1; @(negedge clk); a.start = 0;
    total++;
    if (a.in_ready !== 1'b1 || a.out_valid !== 1'b0) begin
      bad++; $display("FAIL sbusy after pulse: in_ready=%b out_valid=%b want 1 0", a.in_ready, a.out_valid);
    end
    send_a(v[2], 0, "sbusy");
    send_a(v[3], 0, "sbusy");
    exp_q.push_back(model);
    collect_a("sbusy");
  endtask

  task automatic test_reset_mid();
    start_a("rmid");
    send_a(16'd77, 0, "rmid");
    send_a(16'd88, 0, "rmid");
    #2 rst_n = 0;
    #1;
    total++;
    if ({a.acc_out, a.out_valid, a.overflow, a.busy, a.in_ready} !== 28'd0) begin
      bad++; $display("FAIL rmid async: acc=%0h ov=%b of=%b busy=%b rdy=%b want all 0", a.acc_out, a.out_valid, a.overflow, a.busy, a.in_ready);
    end
    @(negedge clk); rst_n = 1;
    start_a("rmid2");
    repeat (4) send_a(16'd1, 0, "rmid2");
    exp_q.push_back(model);
    collect_a("rmid2");
  endtask

  task automatic run_b(input logic [15:0] p0, input logic [15:0] p1, input string nm);
    int s;
    logic [15:0] e;
    logic eo;
    s = int'($signed(p0)) + int'($signed(p1));
    eo = (s > 32767) || (s < -32768);
`ifdef BOOTH_ACC_SATURATE_EN
    e = (s > 32767) ? 16'h7fff : (s < -32768) ? 16'h8000 : 16'(s);
`else
    e = 16'(s);
`endif
    exp_qb.push_back(e); ovf_qb.push_back(eo);
    @(negedge clk); b.start = 1;
    @(negedge clk); b.start = 0;
    total++;
    if (b.in_ready !== 1'b1) begin bad++; $display("FAIL %s in_ready got=%b want 1", nm, b.in_ready); end
    b.in_valid = 1; b.product = p0;
    @(negedge clk); b.product = p1;
    @(negedge clk); b.in_valid = 0;
    e = exp_qb.pop_front(); eo = ovf_qb.pop_front();
    total++;
    if (b.out_valid !== 1'b1 || b.acc_out !== e) begin
      bad++; $display("FAIL %s result: ov=%b acc=%0d want 1 %0d", nm, b.out_valid, $signed(b.acc_out), $signed(e));
    end
    total++;
    if (b.overflow !== eo) begin bad++; $display("FAIL %s overflow got=%b want %b", nm, b.overflow, eo); end
    b.out_ready = 1;
    @(negedge clk); b.out_ready = 0;
    total++;
    if (b.out_valid !== 1'b0 || b.busy !== 1'b0) begin
      bad++; $display("FAIL %s release: ov=%b busy=%b want 0 0", nm, b.out_valid, b.busy);
    end
  endtask

  task automatic test_overflow();
    run_b(16'sd32767, 16'sd1, "ovf_pos");
    run_b(16'd1, 16'd2, "ovf_clear");
    run_b(-16'sd32768, -16'sd1, "ovf_neg");
    run_b(-16'sd5, 16'sd7, "ovf_none");
  endtask

  initial begin
    {a.start, a.in_valid, a.out_ready, a.product} = '0;
    {b.start, b.in_valid, b.out_ready, b.product} = '0;
    test_reset();
    test_basic();
    test_signed_mix();
    test_backpressure();
    test_start_busy();
    test_reset_mid();
    test_overflow();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
